// File: rtl/vram_arbiter.sv
// VRAM port arbiter: scanout reads take strict priority with a fixed 2-cycle return,
// two drawing writers share the remaining cycles round-robin, and long waits raise a sticky starvation flag.
module vram_arbiter #(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 12,
    parameter int STALL_MAX = 1040
) (
    input  logic              MAX10_CLK1_50,
    input  logic              RESET,
    input  logic              frame_start,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_valid,
    input  logic              wr0_valid,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    output logic              wr0_ready,
    input  logic              wr1_valid,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wr_starved
);

    typedef enum logic {PREF_W0 = 1'b0, PREF_W1 = 1'b1} pref_t;

    localparam logic [15:0] STALL_MAX_C = 16'(STALL_MAX);

    pref_t       pref_r;
    logic [1:0]  scan_pipe_r;
    logic [15:0] stall0_r;
    logic [15:0] stall1_r;
    logic        xfer0_s;
    logic        xfer1_s;
    logic        hit0_s;
    logic        hit1_s;

    // Waiting cycles count up to saturation; a transfer or a dropped request restarts the count.
    function automatic logic [15:0] stall_next(input logic [15:0] cnt, input logic valid,
                                               input logic xfer);
        logic [15:0] nxt;
        if (!valid || xfer) begin
            nxt = 16'd0;
        end else if (cnt == STALL_MAX_C) begin
            nxt = cnt;
        end else begin
            nxt = cnt + 16'd1;
        end
        return nxt;
    endfunction

    // Grant logic: a writer's ready looks only at scan_req, the other writer and the pointer.
    always_comb begin
        wr0_ready = 1'b0;
        wr1_ready = 1'b0;
        if (!scan_req) begin
            wr0_ready = !wr1_valid || (pref_r == PREF_W0);
            wr1_ready = !wr0_valid || (pref_r == PREF_W1);
        end else begin
            wr0_ready = 1'b0;
            wr1_ready = 1'b0;
        end
    end

    assign xfer0_s = wr0_valid && wr0_ready;
    assign xfer1_s = wr1_valid && wr1_ready;
    assign hit0_s  = wr0_valid && !xfer0_s && (stall0_r == (STALL_MAX_C - 16'd1));
    assign hit1_s  = wr1_valid && !xfer1_s && (stall1_r == (STALL_MAX_C - 16'd1));

    assign scan_valid = scan_pipe_r[1];
    assign scan_data  = scan_pipe_r[1] ? mem_rdata : {DATA_W{1'b0}};

    // RAM command register: scanout address wins, otherwise the granted write is issued for one cycle.
    always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
        if (RESET) begin
            mem_addr  <= {ADDR_W{1'b0}};
            mem_we    <= 1'b0;
            mem_wdata <= {DATA_W{1'b0}};
        end else if (scan_req) begin
            mem_addr <= scan_addr;
            mem_we   <= 1'b0;
        end else if (xfer0_s) begin
            mem_addr  <= wr0_addr;
            mem_wdata <= wr0_data;
            mem_we    <= 1'b1;
        end else if (xfer1_s) begin
            mem_addr  <= wr1_addr;
            mem_wdata <= wr1_data;
            mem_we    <= 1'b1;
        end else begin
            mem_we <= 1'b0;
        end
    end

    // Round-robin pointer; a transfer on the frame_start edge takes precedence over the rewind.
    always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
        if (RESET) begin
            pref_r <= PREF_W0;
        end else if (xfer0_s) begin
            pref_r <= PREF_W1;
        end else if (xfer1_s) begin
            pref_r <= PREF_W0;
        end else if (frame_start) begin
            pref_r <= PREF_W0;
        end else begin
            pref_r <= pref_r;
        end
    end

    // Scanout valid shift register matching the one-cycle RAM read latency.
    always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
        if (RESET) begin
            scan_pipe_r <= 2'b00;
        end else begin
            scan_pipe_r <= {scan_pipe_r[0], scan_req};
        end
    end

    // Starvation counters and sticky flag; a fresh hit beats the frame_start clear.
    always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
        if (RESET) begin
            stall0_r   <= 16'd0;
            stall1_r   <= 16'd0;
            wr_starved <= 1'b0;
        end else begin
            stall0_r <= stall_next(stall0_r, wr0_valid, xfer0_s);
            stall1_r <= stall_next(stall1_r, wr1_valid, xfer1_s);
            if (hit0_s || hit1_s) begin
                wr_starved <= 1'b1;
            end else if (frame_start) begin
                wr_starved <= 1'b0;
            end else begin
                wr_starved <= wr_starved;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: reset, scanout streaming, round-robin writes,
// frame_start pointer rewind, starvation flag and reset during a write.
module tb_vram_arbiter;

    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 12;
    localparam int STALL_MAX = 1040;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_start;
    logic              scan_req;
    logic [ADDR_W-1:0] scan_addr;
    logic [DATA_W-1:0] scan_data;
    logic              scan_valid;
    logic              wr0_valid;
    logic [ADDR_W-1:0] wr0_addr;
    logic [DATA_W-1:0] wr0_data;
    logic              wr0_ready;
    logic              wr1_valid;
    logic [ADDR_W-1:0] wr1_addr;
    logic [DATA_W-1:0] wr1_data;
    logic              wr1_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              wr_starved;

    int checks   = 0;
    int failures = 0;

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STALL_MAX(STALL_MAX)) dut (
        .MAX10_CLK1_50(clk),
        .RESET(rst),
        .frame_start(frame_start),
        .scan_req(scan_req),
        .scan_addr(scan_addr),
        .scan_data(scan_data),
        .scan_valid(scan_valid),
        .wr0_valid(wr0_valid),
        .wr0_addr(wr0_addr),
        .wr0_data(wr0_data),
        .wr0_ready(wr0_ready),
        .wr1_valid(wr1_valid),
        .wr1_addr(wr1_addr),
        .wr1_data(wr1_data),
        .wr1_ready(wr1_ready),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .wr_starved(wr_starved)
    );

    always #5 clk = ~clk;

    // Fixed RAM contents: word value is a simple function of its address.
    function automatic logic [DATA_W-1:0] ram_f(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] v;
        v = a * 19'd13 + 19'd5;
        return v[DATA_W-1:0];
    endfunction

    // Single-port RAM model with one-cycle read latency.
    always @(posedge clk) mem_rdata <= ram_f(mem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [ADDR_W-1:0] a0;
        logic [ADDR_W-1:0] a1;
        logic              exp_v;

        rst = 1'b1; frame_start = 1'b0; scan_req = 1'b0; scan_addr = '0;
        wr0_valid = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_valid = 1'b0; wr1_addr = '0; wr1_data = '0;
        step();
        step();
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 19'd0);
        chk("rst_mem_wdata", mem_wdata, 12'd0);
        chk("rst_scan_valid", scan_valid, 1'b0);
        chk("rst_starved", wr_starved, 1'b0);
        rst = 1'b0;

        // Idle after reset: lone writer sees ready, no write issued.
        wr0_valid = 1'b1;
        #1 chk("idle_wr0_ready", wr0_ready, 1'b1);
        wr0_valid = 1'b0; wr1_valid = 1'b1;
        #1 chk("idle_wr1_ready", wr1_ready, 1'b1);
        wr1_valid = 1'b0;
        step();
        chk("idle_mem_we", mem_we, 1'b0);
        chk("idle_scan_valid", scan_valid, 1'b0);

        // Scanout burst of 800 reads with a writer held off the whole time.
        for (int j = 0; j <= 802; j++) begin
            scan_req  = (j < 800);
            scan_addr = (j < 800) ? 19'(j) : 19'd0;
            wr1_valid = (j < 800);
            wr1_addr  = 19'h3_0000;
            wr1_data  = 12'hABC;
            #1;
            if (j < 800) chk("scan_no_grant", wr1_ready, 1'b0);
            step();
            exp_v = (j >= 1) && (j <= 800);
            chk("scan_valid", scan_valid, exp_v);
            if (exp_v) chk("scan_data", scan_data, ram_f(19'(j - 1)));
            chk("scan_no_we", mem_we, 1'b0);
        end
        chk("scan_addr_hold", mem_addr, 19'd799);

        // Both writers contending: grants alternate starting with writer 0.
        a0 = 19'h100; a1 = 19'h200;
        wr0_valid = 1'b1; wr1_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wr0_addr = a0; wr0_data = a0[11:0];
            wr1_addr = a1; wr1_data = a1[11:0] ^ 12'h800;
            #1;
            chk("rr_wr0_ready", wr0_ready, (k % 2) == 0);
            chk("rr_wr1_ready", wr1_ready, (k % 2) == 1);
            step();
            chk("rr_mem_we", mem_we, 1'b1);
            if ((k % 2) == 0) begin
                chk("rr_addr0", mem_addr, a0);
                chk("rr_data0", mem_wdata, a0[11:0]);
                a0 = a0 + 19'd1;
            end else begin
                chk("rr_addr1", mem_addr, a1);
                chk("rr_data1", mem_wdata, a1[11:0] ^ 12'h800);
                a1 = a1 + 19'd1;
            end
        end

        // Writer 1 alone, then contention goes to writer 0.
        wr0_valid = 1'b0; wr1_addr = 19'h2_2222; wr1_data = 12'h222;
        #1 chk("solo_wr1_ready", wr1_ready, 1'b1);
        step();
        chk("solo_wr1_addr", mem_addr, 19'h2_2222);
        wr0_valid = 1'b1; wr0_addr = 19'h1_1111; wr0_data = 12'h111;
        #1 chk("after_wr1_wr0_ready", wr0_ready, 1'b1);
        chk("after_wr1_wr1_ready", wr1_ready, 1'b0);
        step();
        chk("after_wr1_addr", mem_addr, 19'h1_1111);
        chk("after_wr1_data", mem_wdata, 12'h111);

        // frame_start without a transfer rewinds the pointer to writer 0.
        wr0_valid = 1'b0; wr1_valid = 1'b0; frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("fs_idle_we", mem_we, 1'b0);
        chk("fs_idle_addr_hold", mem_addr, 19'h1_1111);
        wr0_valid = 1'b1; wr1_valid = 1'b1;
        #1 chk("fs_wr0_ready", wr0_ready, 1'b1);
        chk("fs_wr1_ready", wr1_ready, 1'b0);
        wr1_valid = 1'b0;

        // Writer 0 held off by scanout for STALL_MAX cycles.
        scan_req = 1'b1; scan_addr = 19'd0;
        for (int n = 1; n <= STALL_MAX; n++) begin
            step();
            if (n == STALL_MAX - 1) chk("stall_before_max", wr_starved, 1'b0);
        end
        chk("stall_at_max", wr_starved, 1'b1);
        scan_req = 1'b0;
        #1 chk("stall_release_ready", wr0_ready, 1'b1);
        step();
        chk("stall_sticky", wr_starved, 1'b1);
        chk("stall_write_we", mem_we, 1'b1);
        wr0_valid = 1'b0; frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("stall_fs_clear", wr_starved, 1'b0);

        // A new STALL_MAX hit coinciding with frame_start keeps the flag set.
        scan_req = 1'b1; wr1_valid = 1'b1;
        for (int n = 1; n < STALL_MAX; n++) step();
        chk("coinc_before", wr_starved, 1'b0);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("coinc_set_wins", wr_starved, 1'b1);
        wr1_valid = 1'b0;

        // Reset right after a writer-0 grant with a scanout return outstanding.
        step();
        scan_req = 1'b0; wr0_valid = 1'b1; wr0_addr = 19'h5_4321; wr0_data = 12'h5A5;
        #1 chk("rstmid_grant", wr0_ready, 1'b1);
        step();
        wr0_valid = 1'b0;
        chk("rstmid_we_before", mem_we, 1'b1);
        chk("rstmid_sv_before", scan_valid, 1'b1);
        chk("rstmid_starved_before", wr_starved, 1'b1);
        rst = 1'b1;
        #1;
        chk("rstmid_we", mem_we, 1'b0);
        chk("rstmid_sv", scan_valid, 1'b0);
        chk("rstmid_starved", wr_starved, 1'b0);
        chk("rstmid_addr", mem_addr, 19'd0);
        step();
        rst = 1'b0;
        wr0_valid = 1'b1; wr1_valid = 1'b1;
        #1 chk("rstmid_ptr_wr0", wr0_ready, 1'b1);
        chk("rstmid_ptr_wr1", wr1_ready, 1'b0);
        wr0_valid = 1'b0; wr1_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
